if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core, instantiated inside Top directly upstream of the ID stage.
- Holds the PC and drives the word address of the instruction memory, which has a combinational read port.
- Captures the fetched instruction and PC+4 into the IF/ID pipeline register.
- Honours a stall input from the hazard unit and a redirect (branch/jump) input from ID, which also flushes IF/ID.

---
 rtl/if_stage.sv | 93 +++++++++
 tb/tb_if_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory
// and loads the IF/ID pipeline register for the decode stage.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IM_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_en,
  input  logic [31:0]          redirect_pc,
  output logic [IM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]          imem_data,
  output logic [31:0]          pc,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc_plus4,
  output logic                 if_id_valid,
  output logic                 misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;

  logic [31:0] pc_plus4;
  logic [31:0] tgt_pc;
  logic        tgt_mis;

  // Sequential successor wraps naturally at 2^32.
  assign pc_plus4 = pc_q + 32'd4;

  // Redirect targets are forced onto a word boundary.
  assign tgt_pc  = {redirect_pc[31:2], 2'b00};
  assign tgt_mis = |redirect_pc[1:0];

  // Upper PC bits are dropped, so the memory aliases.
  assign imem_addr = pc_q[IM_ADDR_W+1:2];

  // Next-state selection: redirect beats stall beats advance.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    priority case (1'b1)
      redirect_en: begin
        pc_d    = tgt_pc;
        instr_d = NOP;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
        mis_d   = mis_q | tgt_mis;
      end
      stall: begin
        pc_d    = pc_q;
      end
      default: begin
        pc_d    = pc_plus4;
        instr_d = imem_data;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    endcase
  end

  // State update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign misalign_err   = mis_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a combinational
// instruction memory holding 32'h2000_0000 + word index.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'h2000_0000 + {24'd0, imem_addr};

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .IM_ADDR_W(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .misalign_err  (misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; stall = 0; redirect_en = 0; redirect_pc = 0;
    step();
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0);
    end
    n_checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
        if_id_pc_plus4 !== 32'h0 || misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ifid got v=%b i=%h p=%h m=%b exp 0 0 0 0",
               if_id_valid, if_id_instr, if_id_pc_plus4, misalign_err);
    end
  endtask

  task automatic test_seq_fetch();
    reset = 1;
    step();
    n_checks++;
    if (pc !== 32'h4 || if_id_instr !== 32'h2000_0000 ||
        if_id_pc_plus4 !== 32'h4 || if_id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL seq1 got pc=%h i=%h p=%h v=%b exp 4 20000000 4 1",
               pc, if_id_instr, if_id_pc_plus4, if_id_valid);
    end
    step();
    n_checks++;
    if (pc !== 32'h8 || if_id_instr !== 32'h2000_0001 ||
        if_id_pc_plus4 !== 32'h8) begin
      n_fail++;
      $display("FAIL seq2 got pc=%h i=%h p=%h exp 8 20000001 8",
               pc, if_id_instr, if_id_pc_plus4);
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (pc !== 32'h8 || if_id_instr !== 32'h2000_0001 ||
          if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h8) begin
        n_fail++;
        $display("FAIL stall%0d got pc=%h i=%h v=%b exp 8 20000001 1",
                 k, pc, if_id_instr, if_id_valid);
      end
    end
    stall = 0;
    step();
    n_checks++;
    if (pc !== 32'hC || if_id_instr !== 32'h2000_0002 ||
        if_id_pc_plus4 !== 32'hC) begin
      n_fail++;
      $display("FAIL stall_rel got pc=%h i=%h p=%h exp c 20000002 c",
               pc, if_id_instr, if_id_pc_plus4);
    end
  endtask

  task automatic test_redirect();
    redirect_en = 1; redirect_pc = 32'h40;
    step();
    redirect_en = 0;
    n_checks++;
    if (pc !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
        if_id_pc_plus4 !== 32'h0) begin
      n_fail++;
      $display("FAIL redir got pc=%h v=%b i=%h p=%h exp 40 0 0 0",
               pc, if_id_valid, if_id_instr, if_id_pc_plus4);
    end
    step();
    n_checks++;
    if (if_id_instr !== 32'h2000_0010 || if_id_pc_plus4 !== 32'h44 ||
        if_id_valid !== 1'b1 || pc !== 32'h44) begin
      n_fail++;
      $display("FAIL redir_tgt got i=%h p=%h v=%b pc=%h exp 20000010 44 1 44",
               if_id_instr, if_id_pc_plus4, if_id_valid, pc);
    end
  endtask

  task automatic test_redirect_over_stall();
    stall = 1; redirect_en = 1; redirect_pc = 32'h80;
    step();
    stall = 0; redirect_en = 0;
    n_checks++;
    if (pc !== 32'h80 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
        misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_stall got pc=%h v=%b i=%h m=%b exp 80 0 0 0",
               pc, if_id_valid, if_id_instr, misalign_err);
    end
  endtask

  task automatic test_misalign();
    redirect_en = 1; redirect_pc = 32'h23;
    step();
    redirect_en = 0;
    n_checks++;
    if (pc !== 32'h20 || misalign_err !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign got pc=%h m=%b exp 20 1", pc, misalign_err);
    end
    step();
    n_checks++;
    if (pc !== 32'h24 || if_id_instr !== 32'h2000_0008 ||
        misalign_err !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_sticky got pc=%h i=%h m=%b exp 24 20000008 1",
               pc, if_id_instr, misalign_err);
    end
    reset = 0;
    step();
    reset = 1;
    n_checks++;
    if (pc !== 32'h0 || misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_clear got pc=%h m=%b exp 0 0", pc, misalign_err);
    end
  endtask

  task automatic test_reset_mid_stall();
    redirect_en = 1; redirect_pc = 32'h44;
    step();
    redirect_en = 0;
    step();
    stall = 1;
    step();
    n_checks++;
    if (pc !== 32'h48 || if_id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst got pc=%h v=%b exp 48 1", pc, if_id_valid);
    end
    reset = 0;
    step();
    n_checks++;
    if (pc !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_stall got pc=%h v=%b i=%h exp 0 0 0",
               pc, if_id_valid, if_id_instr);
    end
    reset = 1; stall = 0;
  endtask

  task automatic test_wrap_alias();
    redirect_en = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_en = 0;
    n_checks++;
    if (pc !== 32'hFFFF_FFFC || imem_addr !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_pre got pc=%h a=%h exp fffffffc ff", pc, imem_addr);
    end
    step();
    n_checks++;
    if (pc !== 32'h0 || if_id_pc_plus4 !== 32'h0 ||
        if_id_instr !== 32'h2000_00FF || if_id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap got pc=%h p=%h i=%h v=%b exp 0 0 200000ff 1",
               pc, if_id_pc_plus4, if_id_instr, if_id_valid);
    end
    redirect_en = 1; redirect_pc = 32'h0000_0408;
    step();
    redirect_en = 0;
    n_checks++;
    if (imem_addr !== 8'h02) begin
      n_fail++;
      $display("FAIL alias_addr got %h exp 02", imem_addr);
    end
    step();
    n_checks++;
    if (if_id_instr !== 32'h2000_0002 || if_id_pc_plus4 !== 32'h40C) begin
      n_fail++;
      $display("FAIL alias got i=%h p=%h exp 20000002 40c",
               if_id_instr, if_id_pc_plus4);
    end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_stall();
    test_redirect();
    test_redirect_over_stall();
    test_misalign();
    test_reset_mid_stall();
    test_wrap_alias();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
